// File: rtl/time_entry_controller.sv
// HH:MM time entry sequencer for the alarm clock.
// Accepts single-cycle press pulses from the edge-detect stage, steps the
// cursor through H1,H0,M1,M0 and a confirm position, validates each digit,
// and issues a one-cycle commit to either the clock or the alarm register.
//
// Handshake: there is no valid/ready; every input bit is a one-cycle pulse
// that is consumed on the rising edge where it is high, and every output
// (including the strobes) is registered, so the response to a pulse is
// visible one edge later. Strobes are single-cycle and never back-pressured.
module time_entry_controller #(
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] keyboard_down,
  input  logic [4:0]  button_down,
  output logic        entry_active,
  output logic        entry_target,
  output logic [2:0]  cursor,
  output logic [15:0] entry_digits,
  output logic        commit_clock,
  output logic        commit_alarm,
  output logic [15:0] commit_value,
  output logic        error,
  output logic        timeout,
  output logic [1:0]  debug_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIG     = 2'd1,
    S_CONFIRM = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    cursor_n;
  logic [15:0]   digits_n, value_n;
  logic          target_n, cc_n, ca_n, err_n, to_n;
  logic [12:0]   kb;
  logic          key_event, digit_ok, any_button;
  logic [3:0]    key_code;
  logic          unused_inputs;

  // Reserved key and button bits carry no meaning here.
  assign unused_inputs = ^{keyboard_down[15:13], button_down[4:2]};

  assign entry_active = (state != S_IDLE);
  assign debug_state  = state;
  assign any_button   = button_down[0] | button_down[1];

  // Write one BCD nibble; position 0 is H1 in the top nibble.
  function automatic logic [15:0] put_nibble(input logic [15:0] v,
                                             input logic [2:0] pos,
                                             input logic [3:0] n);
    logic [15:0] r;
    r = v;
    case (pos)
      3'd0:    r[15:12] = n;
      3'd1:    r[11:8]  = n;
      3'd2:    r[7:4]   = n;
      3'd3:    r[3:0]   = n;
      default: r = v;
    endcase
    return r;
  endfunction

  // Decode the keyboard: exactly one of the 13 live bits is a key event.
  always_comb begin
    kb        = keyboard_down[12:0];
    key_event = (kb != 13'd0) && ((kb & (kb - 13'd1)) == 13'd0);
    key_code  = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (kb[i]) key_code = 4'(i);
    end
  end

  // Digit range check for the position under the cursor (hours cap at 23).
  always_comb begin
    digit_ok = 1'b0;
    case (cursor)
      3'd0:    digit_ok = (key_code <= 4'd2);
      3'd1:    digit_ok = (entry_digits[15:12] == 4'd2) ? (key_code <= 4'd3) : 1'b1;
      3'd2:    digit_ok = (key_code <= 4'd5);
      3'd3:    digit_ok = 1'b1;
      default: digit_ok = 1'b0;
    endcase
  end

  // Next-state and next-output logic; buttons outrank keys, events outrank timeout.
  always_comb begin
    state_n  = state;
    cursor_n = cursor;
    digits_n = entry_digits;
    target_n = entry_target;
    value_n  = commit_value;
    cc_n     = 1'b0;
    ca_n     = 1'b0;
    err_n    = 1'b0;
    to_n     = 1'b0;
    cnt_n    = (state == S_IDLE) ? '0 : cnt + 1'b1;

    if (any_button) begin
      state_n  = S_DIG;
      target_n = ~button_down[0];
      cursor_n = 3'd0;
      digits_n = 16'd0;
      cnt_n    = '0;
    end else if (state != S_IDLE && key_event) begin
      cnt_n = '0;
      if (key_code <= 4'd9) begin
        if (state == S_CONFIRM || !digit_ok) begin
          err_n = 1'b1;
        end else begin
          digits_n = put_nibble(entry_digits, cursor, key_code);
          cursor_n = cursor + 3'd1;
          if (cursor == 3'd3) state_n = S_CONFIRM;
        end
      end else if (key_code == 4'd10) begin
        if (cursor != 3'd0) begin
          cursor_n = cursor - 3'd1;
          digits_n = put_nibble(entry_digits, cursor - 3'd1, 4'd0);
          state_n  = S_DIG;
        end
      end else if (key_code == 4'd11) begin
        state_n  = S_IDLE;
        cursor_n = 3'd0;
        digits_n = 16'd0;
      end else begin
        if (state == S_CONFIRM) begin
          value_n  = entry_digits;
          cc_n     = ~entry_target;
          ca_n     = entry_target;
          state_n  = S_IDLE;
          cursor_n = 3'd0;
          digits_n = 16'd0;
        end else begin
          err_n = 1'b1;
        end
      end
    end else if (state != S_IDLE && cnt == CNT_MAX) begin
      to_n     = 1'b1;
      state_n  = S_IDLE;
      cursor_n = 3'd0;
      digits_n = 16'd0;
      cnt_n    = '0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      cursor       <= 3'd0;
      entry_digits <= 16'd0;
      entry_target <= 1'b0;
      commit_value <= 16'd0;
      commit_clock <= 1'b0;
      commit_alarm <= 1'b0;
      error        <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      cursor       <= cursor_n;
      entry_digits <= digits_n;
      entry_target <= target_n;
      commit_value <= value_n;
      commit_clock <= cc_n;
      commit_alarm <= ca_n;
      error        <= err_n;
      timeout      <= to_n;
    end
  end

endmodule

// File: tb/tb_time_entry_controller.sv
// Bench for time_entry_controller: directed scenarios plus randomized
// traffic, all checked against a behavioural entry model.
module tb_time_entry_controller;

  localparam int T   = 8;
  localparam int BS  = 10;
  localparam int CAN = 11;
  localparam int ENT = 12;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] keyboard_down;
  logic [4:0]  button_down;
  logic        entry_active, entry_target;
  logic [2:0]  cursor;
  logic [15:0] entry_digits, commit_value;
  logic        commit_clock, commit_alarm, error, timeout;
  logic [1:0]  debug_state;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  time_entry_controller #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset_n(reset_n),
    .keyboard_down(keyboard_down), .button_down(button_down),
    .entry_active(entry_active), .entry_target(entry_target),
    .cursor(cursor), .entry_digits(entry_digits),
    .commit_clock(commit_clock), .commit_alarm(commit_alarm),
    .commit_value(commit_value), .error(error), .timeout(timeout),
    .debug_state(debug_state)
  );

  // Clock
  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  // An entry is a list of typed digits (m_n of them, 4 = complete) and a
  // record of the cycle of the last user event.
  bit          m_active, m_target, m_cc, m_ca, m_err, m_to;
  int          m_n, m_cyc, m_last;
  int          m_d[4];
  logic [15:0] m_value;

  function automatic logic [15:0] m_digits();
    return {4'(m_d[0]), 4'(m_d[1]), 4'(m_d[2]), 4'(m_d[3])};
  endfunction

  function automatic logic [2:0] m_cursor();
    return m_active ? 3'(m_n) : 3'd0;
  endfunction

  function automatic logic [15:0] key(input int c);
    logic [15:0] v;
    v = 16'd0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic m_close();
    m_active = 0;
    m_n = 0;
    for (int i = 0; i < 4; i++) m_d[i] = 0;
  endtask

  task automatic model_reset();
    m_close();
    m_target = 0; m_value = 16'd0;
    m_cc = 0; m_ca = 0; m_err = 0; m_to = 0;
    m_cyc = 0; m_last = 0;
  endtask

  // Can digit v sit at position p given what is already typed (time <= 23:59)?
  function automatic bit m_fits(input int p, input int v);
    case (p)
      0:       return v <= 2;
      1:       return (m_d[0] * 10 + v) <= 23;
      2:       return v <= 5;
      default: return 1;
    endcase
  endfunction

  task automatic model_step(input logic [15:0] kb, input logic [4:0] btn);
    int nkeys, code;
    m_cyc++;
    m_cc = 0; m_ca = 0; m_err = 0; m_to = 0;
    nkeys = $countones(kb[12:0]);
    code = 0;
    for (int i = 0; i < 13; i++) if (kb[i]) code = i;
    if (btn[0] || btn[1]) begin
      m_close();
      m_active = 1;
      m_target = !btn[0];
      m_last = m_cyc;
    end else if (m_active && nkeys == 1) begin
      m_last = m_cyc;
      if (code <= 9) begin
        if (m_n == 4 || !m_fits(m_n, code)) m_err = 1;
        else begin m_d[m_n] = code; m_n++; end
      end else if (code == BS) begin
        if (m_n > 0) begin m_n--; m_d[m_n] = 0; end
      end else if (code == CAN) begin
        m_close();
      end else if (m_n == 4) begin
        m_value = m_digits();
        if (m_target) m_ca = 1; else m_cc = 1;
        exp_q.push_back(m_value);
        m_close();
      end else begin
        m_err = 1;
      end
    end else if (m_active && (m_cyc - m_last) == T) begin
      m_to = 1;
      m_close();
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [15:0] kb, input logic [4:0] btn);
    @(negedge clock);
    keyboard_down = kb;
    button_down   = btn;
    model_step(kb, btn);
    @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; keyboard_down = 16'd0; button_down = 5'd0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({entry_active, entry_target, cursor, entry_digits, commit_clock, commit_alarm,
         commit_value, error, timeout} !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs: got act=%b tgt=%b cur=%0d dig=%h cc=%b ca=%b val=%h err=%b to=%b, want all 0",
               entry_active, entry_target, cursor, entry_digits, commit_clock, commit_alarm,
               commit_value, error, timeout);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_clock_entry();
    cycle(16'd0, 5'b00001);
    checks++;
    if (entry_active !== 1'b1 || entry_target !== 1'b0 || cursor !== 3'd0) begin
      errors++;
      $display("FAIL clock_open: act=%b tgt=%b cur=%0d, want 1 0 0", entry_active, entry_target, cursor);
    end
    for (int i = 1; i <= 4; i++) begin
      cycle(key(i), 5'd0);
      checks++;
      if (cursor !== 3'(i)) begin
        errors++;
        $display("FAIL clock_cursor: got %0d want %0d", cursor, i);
      end
    end
    cycle(key(ENT), 5'd0);
    checks++;
    if (commit_clock !== 1'b1 || commit_alarm !== 1'b0 || commit_value !== 16'h1234 ||
        entry_active !== 1'b0) begin
      errors++;
      $display("FAIL clock_commit: cc=%b ca=%b val=%h act=%b, want 1 0 1234 0",
               commit_clock, commit_alarm, commit_value, entry_active);
    end
    cycle(16'd0, 5'd0);
    checks++;
    if (commit_clock !== 1'b0 || commit_value !== 16'h1234) begin
      errors++;
      $display("FAIL clock_strobe_drop: cc=%b val=%h, want 0 1234", commit_clock, commit_value);
    end
  endtask

  task automatic test_alarm_entry();
    cycle(16'd0, 5'b00010);
    cycle(key(2), 5'd0);
    cycle(key(4), 5'd0);
    checks++;
    if (error !== 1'b1 || cursor !== 3'd1 || entry_digits !== 16'h2000) begin
      errors++;
      $display("FAIL alarm_bad_h0: err=%b cur=%0d dig=%h, want 1 1 2000", error, cursor, entry_digits);
    end
    cycle(key(3), 5'd0);
    checks++;
    if (error !== 1'b0 || cursor !== 3'd2) begin
      errors++;
      $display("FAIL alarm_h0: err=%b cur=%0d, want 0 2", error, cursor);
    end
    cycle(key(5), 5'd0);
    cycle(key(9), 5'd0);
    checks++;
    if (cursor !== 3'd4 || entry_digits !== 16'h2359) begin
      errors++;
      $display("FAIL alarm_confirm: cur=%0d dig=%h, want 4 2359", cursor, entry_digits);
    end
    cycle(key(ENT), 5'd0);
    checks++;
    if (commit_alarm !== 1'b1 || commit_clock !== 1'b0 || commit_value !== 16'h2359) begin
      errors++;
      $display("FAIL alarm_commit: ca=%b cc=%b val=%h, want 1 0 2359", commit_alarm, commit_clock, commit_value);
    end
  endtask

  task automatic test_backspace_cancel();
    cycle(16'd0, 5'b00001);
    cycle(key(1), 5'd0);
    cycle(key(7), 5'd0);
    cycle(key(BS), 5'd0);
    cycle(key(8), 5'd0);
    checks++;
    if (entry_digits !== 16'h1800 || cursor !== 3'd2) begin
      errors++;
      $display("FAIL backspace: dig=%h cur=%0d, want 1800 2", entry_digits, cursor);
    end
    cycle(key(CAN), 5'd0);
    checks++;
    if (entry_active !== 1'b0 || entry_digits !== 16'd0 || commit_clock !== 1'b0 ||
        commit_alarm !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL cancel: act=%b dig=%h cc=%b ca=%b err=%b, want 0 0000 0 0 0",
               entry_active, entry_digits, commit_clock, commit_alarm, error);
    end
  endtask

  task automatic test_multi_key();
    cycle(16'd0, 5'b00001);
    cycle(key(1), 5'd0);
    cycle(key(2), 5'd0);
    cycle(16'h0003, 5'd0);
    checks++;
    if (cursor !== 3'd2 || entry_digits !== 16'h1200 || error !== 1'b0) begin
      errors++;
      $display("FAIL multi_key: cur=%0d dig=%h err=%b, want 2 1200 0", cursor, entry_digits, error);
    end
    cycle(key(ENT), 5'd0);
    checks++;
    if (error !== 1'b1 || cursor !== 3'd2 || commit_clock !== 1'b0) begin
      errors++;
      $display("FAIL early_enter: err=%b cur=%0d cc=%b, want 1 2 0", error, cursor, commit_clock);
    end
    cycle(16'hE000 | key(3), 5'd0);
    checks++;
    if (error !== 1'b0 || cursor !== 3'd3 || entry_digits !== 16'h1230) begin
      errors++;
      $display("FAIL high_bits: err=%b cur=%0d dig=%h, want 0 3 1230", error, cursor, entry_digits);
    end
    cycle(key(CAN), 5'd0);
  endtask

  task automatic test_timeout();
    cycle(16'd0, 5'b00001);
    cycle(key(1), 5'd0);
    for (int i = 1; i <= T; i++) begin
      cycle(16'd0, 5'd0);
      checks++;
      if (timeout !== (i == T) || entry_active !== (i != T)) begin
        errors++;
        $display("FAIL timeout_at_%0d: to=%b act=%b, want %b %b", i, timeout, entry_active, i == T, i != T);
      end
    end
    checks++;
    if (entry_digits !== 16'd0 || cursor !== 3'd0) begin
      errors++;
      $display("FAIL timeout_clear: dig=%h cur=%0d, want 0000 0", entry_digits, cursor);
    end
    cycle(16'd0, 5'b00001);
    cycle(key(1), 5'd0);
    repeat (T - 1) cycle(16'd0, 5'd0);
    cycle(key(2), 5'd0);
    checks++;
    if (timeout !== 1'b0 || entry_active !== 1'b1 || cursor !== 3'd2) begin
      errors++;
      $display("FAIL timeout_event_wins: to=%b act=%b cur=%0d, want 0 1 2", timeout, entry_active, cursor);
    end
    cycle(key(CAN), 5'd0);
  endtask

  task automatic test_restart_and_reset();
    cycle(16'd0, 5'b00001);
    cycle(key(1), 5'd0);
    cycle(key(2), 5'd0);
    cycle(key(3), 5'd0);
    cycle(16'd0, 5'b00010);
    checks++;
    if (entry_target !== 1'b1 || cursor !== 3'd0 || entry_digits !== 16'd0 || entry_active !== 1'b1) begin
      errors++;
      $display("FAIL restart: tgt=%b cur=%0d dig=%h act=%b, want 1 0 0000 1",
               entry_target, cursor, entry_digits, entry_active);
    end
    cycle(key(1), 5'b00011);
    checks++;
    if (entry_target !== 1'b0 || cursor !== 3'd0 || entry_digits !== 16'd0) begin
      errors++;
      $display("FAIL button_beats_key: tgt=%b cur=%0d dig=%h, want 0 0 0000", entry_target, cursor, entry_digits);
    end
    cycle(key(1), 5'd0);
    cycle(key(2), 5'd0);
    @(negedge clock);
    keyboard_down = 16'd0;
    button_down   = 5'd0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({entry_active, entry_target, cursor, entry_digits, commit_clock, commit_alarm,
         commit_value, error, timeout} !== 40'd0) begin
      errors++;
      $display("FAIL async_reset: act=%b cur=%0d dig=%h val=%h, want all 0",
               entry_active, cursor, entry_digits, commit_value);
    end
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] kb, got;
    logic [4:0]  btn;
    int r, burst, a, b;
    exp_q.delete();
    for (int n = 0; n < 2500; n++) begin
      r = $urandom_range(0, 99);
      kb = 16'd0; btn = 5'd0; burst = 1;
      if (r < 30)      kb = 16'd0;
      else if (r < 70) kb = key($urandom_range(0, 9));
      else if (r < 76) kb = key(BS);
      else if (r < 79) kb = key(CAN);
      else if (r < 86) kb = key(ENT);
      else if (r < 89) begin
        a = $urandom_range(0, 12);
        b = (a + $urandom_range(1, 12)) % 13;
        kb = key(a) | key(b);
      end else if (r < 93) begin
        btn = 5'($urandom_range(1, 31));
        kb  = key($urandom_range(0, 12));
      end else if (r < 96) kb = 16'($urandom_range(0, 7)) << 13;
      else burst = T + 1;
      for (int k = 0; k < burst; k++) begin
        if (k > 0) begin kb = 16'd0; btn = 5'd0; end
        cycle(kb, btn);
        checks++;
        if ({entry_active, entry_target, cursor, entry_digits, commit_clock, commit_alarm,
             commit_value, error, timeout} !==
            {m_active, m_target, m_cursor(), m_digits(), m_cc, m_ca, m_value, m_err, m_to}) begin
          errors++;
          $display("FAIL random_%0d: got act=%b tgt=%b cur=%0d dig=%h cc=%b ca=%b val=%h err=%b to=%b; want act=%b tgt=%b cur=%0d dig=%h cc=%b ca=%b val=%h err=%b to=%b",
                   n, entry_active, entry_target, cursor, entry_digits, commit_clock, commit_alarm,
                   commit_value, error, timeout, m_active, m_target, m_cursor(), m_digits(),
                   m_cc, m_ca, m_value, m_err, m_to);
        end
        if (commit_clock || commit_alarm) begin
          checks++;
          got = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
          if (commit_value !== got) begin
            errors++;
            $display("FAIL random_commit_value: got %h want %h", commit_value, got);
          end
        end
      end
    end
    cycle(16'd0, 5'd0);
  endtask

  // Sequencer
  initial begin
    test_reset();
    test_clock_entry();
    test_alarm_entry();
    test_backspace_cancel();
    test_multi_key();
    test_timeout();
    test_restart_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
